// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states and port ownership.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } arb_state_e;

    typedef enum logic {
        OwnI = 1'b0,
        OwnD = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational grant selection between the fetch and data ports.
module mem_arb_picker
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned RR_EN = 0
) (
    input  logic   i_req,
    input  logic   d_req,
    input  owner_e last_owner,
    output logic   grant_valid,
    output owner_e grant_owner
);

    always_comb begin
        grant_valid = i_req | d_req;
        grant_owner = OwnI;
        if (d_req && !i_req) begin
            grant_owner = OwnD;
        end else if (d_req && i_req) begin
            // On a tie, round-robin hands the grant to whoever did not win last time.
            if (RR_EN != 0) begin
                grant_owner = (last_owner == OwnI) ? OwnD : OwnI;
            end else begin
                grant_owner = OwnD;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one ram_top between the instruction-fetch and data ports: serialises accesses,
// holds the downstream request stable, routes the response and aborts hung accesses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned RR_EN   = 0,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_valid,
    output logic              i_err,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_mask,
    output logic [31:0]       d_rdata,
    output logic              d_valid,
    output logic              d_err,
    output logic              mem_request,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_mask,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_valid
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] WdLast = CntW'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_owner_q, last_owner_d;
    logic [CntW-1:0]   wd_cnt_q, wd_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_mask_q, mem_mask_d;

    logic   grant_valid;
    owner_e grant_owner;

    mem_arb_picker #(
        .RR_EN (RR_EN)
    ) u_picker (
        .i_req       (i_req),
        .d_req       (d_req),
        .last_owner  (last_owner_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            owner_q      <= OwnI;
            last_owner_q <= OwnD;
            wd_cnt_q     <= '0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            mem_mask_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            wd_cnt_q     <= wd_cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_mask_q   <= mem_mask_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        wd_cnt_d     = wd_cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = mem_we_q;
        mem_wdata_d  = mem_wdata_q;
        mem_mask_d   = mem_mask_q;
        i_valid      = 1'b0;
        i_err        = 1'b0;
        d_valid      = 1'b0;
        d_err        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    owner_d      = grant_owner;
                    last_owner_d = grant_owner;
                    wd_cnt_d     = '0;
                    state_d      = StBusy;
                    if (grant_owner == OwnD) begin
                        mem_addr_d  = d_addr;
                        mem_we_d    = d_we;
                        mem_wdata_d = d_wdata;
                        mem_mask_d  = d_mask;
                    end else begin
                        // Fetches are reads: never let stale store controls leak through.
                        mem_addr_d  = i_addr;
                        mem_we_d    = 1'b0;
                        mem_wdata_d = '0;
                        mem_mask_d  = '0;
                    end
                end
            end
            StBusy: begin
                if (mem_valid) begin
                    i_valid = (owner_q == OwnI);
                    d_valid = (owner_q == OwnD);
                    state_d = StDone;
                end else if (wd_cnt_q == WdLast) begin
                    i_err   = (owner_q == OwnI);
                    d_err   = (owner_q == OwnD);
                    state_d = StDone;
                end else begin
                    wd_cnt_d = wd_cnt_q + CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Derived from state so an asynchronous reset drops the request immediately.
    assign mem_request = (state_q == StBusy);
    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_mask    = mem_mask_q;
    assign i_rdata     = mem_rdata;
    assign d_rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fixed-priority/short-timeout instance A plus a
// round-robin instance B, each backed by a simple ram_top latency model.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int npass = 0;
    int ntotal = 0;

    // ---------------- instance A: RR_EN=0, TIMEOUT=8 ----------------
    logic        a_i_req = 1'b0;
    logic [7:0]  a_i_addr = '0;
    logic [31:0] a_i_rdata;
    logic        a_i_valid, a_i_err;
    logic        a_d_req = 1'b0;
    logic [7:0]  a_d_addr = '0;
    logic        a_d_we = 1'b0;
    logic [31:0] a_d_wdata = '0;
    logic [3:0]  a_d_mask = '0;
    logic [31:0] a_d_rdata;
    logic        a_d_valid, a_d_err;
    logic        a_mem_request, a_mem_we;
    logic [7:0]  a_mem_addr;
    logic [31:0] a_mem_wdata;
    logic [3:0]  a_mem_mask;
    logic [31:0] a_mem_rdata;
    logic        a_mem_valid;
    logic        a_model_valid;
    logic        inj_valid = 1'b0;
    logic        silent = 1'b0;
    int          lat_a = 1;
    int          a_cnt;

    assign a_mem_valid = a_model_valid | inj_valid;

    mem_port_arbiter #(
        .ADDR_W  (8),
        .RR_EN   (0),
        .TIMEOUT (8)
    ) dut_a (
        .clk         (clk),
        .rst         (rst),
        .i_req       (a_i_req),
        .i_addr      (a_i_addr),
        .i_rdata     (a_i_rdata),
        .i_valid     (a_i_valid),
        .i_err       (a_i_err),
        .d_req       (a_d_req),
        .d_addr      (a_d_addr),
        .d_we        (a_d_we),
        .d_wdata     (a_d_wdata),
        .d_mask      (a_d_mask),
        .d_rdata     (a_d_rdata),
        .d_valid     (a_d_valid),
        .d_err       (a_d_err),
        .mem_request (a_mem_request),
        .mem_addr    (a_mem_addr),
        .mem_we      (a_mem_we),
        .mem_wdata   (a_mem_wdata),
        .mem_mask    (a_mem_mask),
        .mem_rdata   (a_mem_rdata),
        .mem_valid   (a_mem_valid)
    );

    // ---------------- instance B: RR_EN=1, TIMEOUT=64 ----------------
    logic        b_i_req = 1'b0;
    logic [7:0]  b_i_addr = '0;
    logic [31:0] b_i_rdata;
    logic        b_i_valid, b_i_err;
    logic        b_d_req = 1'b0;
    logic [7:0]  b_d_addr = '0;
    logic [31:0] b_d_rdata;
    logic        b_d_valid, b_d_err;
    logic        b_mem_request, b_mem_we;
    logic [7:0]  b_mem_addr;
    logic [31:0] b_mem_wdata;
    logic [3:0]  b_mem_mask;
    logic [31:0] b_mem_rdata;
    logic        b_mem_valid;
    int          b_cnt;

    mem_port_arbiter #(
        .ADDR_W  (8),
        .RR_EN   (1),
        .TIMEOUT (64)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .i_req       (b_i_req),
        .i_addr      (b_i_addr),
        .i_rdata     (b_i_rdata),
        .i_valid     (b_i_valid),
        .i_err       (b_i_err),
        .d_req       (b_d_req),
        .d_addr      (b_d_addr),
        .d_we        (1'b0),
        .d_wdata     (32'h0),
        .d_mask      (4'h0),
        .d_rdata     (b_d_rdata),
        .d_valid     (b_d_valid),
        .d_err       (b_d_err),
        .mem_request (b_mem_request),
        .mem_addr    (b_mem_addr),
        .mem_we      (b_mem_we),
        .mem_wdata   (b_mem_wdata),
        .mem_mask    (b_mem_mask),
        .mem_rdata   (b_mem_rdata),
        .mem_valid   (b_mem_valid)
    );

    // ---------------- ram_top models ----------------
    logic [31:0] mem_a [256];

    // Word k holds A5A5A5kk; word 0x20 is preset to 12345678 for the store test.
    always @(posedge clk) begin
        a_model_valid <= 1'b0;
        if (rst) begin
            for (int k = 0; k < 256; k++) mem_a[k] <= {24'hA5A5A5, 8'(k)};
            mem_a[32] <= 32'h12345678;
            a_cnt <= 0;
        end else if (!a_mem_request) begin
            a_cnt <= 0;
        end else begin
            a_cnt <= a_cnt + 1;
            if (a_cnt == lat_a - 1 && !silent) begin
                a_model_valid <= 1'b1;
                a_mem_rdata   <= mem_a[a_mem_addr];
                if (a_mem_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (a_mem_mask[b]) mem_a[a_mem_addr][8*b +: 8] <= a_mem_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        b_mem_valid <= 1'b0;
        if (rst || !b_mem_request) begin
            b_cnt <= 0;
        end else begin
            b_cnt <= b_cnt + 1;
            if (b_cnt == 0) begin
                b_mem_valid <= 1'b1;
                b_mem_rdata <= mem_a[b_mem_addr];
            end
        end
    end

    // Pulse counters for instance A (monotonic; tasks take snapshots).
    int ai_cnt = 0, ad_cnt = 0, aie_cnt = 0, ade_cnt = 0;
    always @(posedge clk) begin
        if (a_i_valid) ai_cnt <= ai_cnt + 1;
        if (a_d_valid) ad_cnt <= ad_cnt + 1;
        if (a_i_err) aie_cnt <= aie_cnt + 1;
        if (a_d_err) ade_cnt <= ade_cnt + 1;
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        ntotal++;
        if (a_mem_request !== 1'b0 || b_mem_request !== 1'b0)
            $display("FAIL reset_request: got a=%b b=%b want 0", a_mem_request, b_mem_request);
        else npass++;
        ntotal++;
        if ({a_mem_addr, a_mem_we, a_mem_wdata, a_mem_mask} !== 45'h0)
            $display("FAIL reset_mem_regs: got addr=%h we=%b wdata=%h mask=%h want all 0",
                     a_mem_addr, a_mem_we, a_mem_wdata, a_mem_mask);
        else npass++;
        ntotal++;
        if ({a_i_valid, a_i_err, a_d_valid, a_d_err} !== 4'b0000)
            $display("FAIL reset_pulses: got %b want 0000",
                     {a_i_valid, a_i_err, a_d_valid, a_d_err});
        else npass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        int bi = ai_cnt;
        int bd = ad_cnt;
        a_i_addr = 8'h04;
        a_i_req  = 1'b1;
        #1;
        ntotal++;
        if (a_mem_request !== 1'b0) $display("FAIL fetch_no_early_req: got %b want 0", a_mem_request);
        else npass++;
        @(negedge clk);
        ntotal++;
        if (a_mem_request !== 1'b1) $display("FAIL fetch_req_rise: got %b want 1", a_mem_request);
        else npass++;
        ntotal++;
        if ({a_mem_addr, a_mem_we, a_mem_mask} !== {8'h04, 1'b0, 4'h0})
            $display("FAIL fetch_mem_ctrl: got addr=%h we=%b mask=%h want 04/0/0",
                     a_mem_addr, a_mem_we, a_mem_mask);
        else npass++;
        for (int k = 0; k < 20 && a_i_valid !== 1'b1; k++) @(negedge clk);
        ntotal++;
        if (a_i_valid !== 1'b1) $display("FAIL fetch_valid: got %b want 1", a_i_valid);
        else npass++;
        ntotal++;
        if (a_i_rdata !== 32'hA5A5A504) $display("FAIL fetch_rdata: got %h want a5a5a504", a_i_rdata);
        else npass++;
        a_i_req = 1'b0;
        repeat (4) @(negedge clk);
        ntotal++;
        if (ai_cnt - bi !== 1 || ad_cnt - bd !== 0)
            $display("FAIL fetch_pulse_count: got i=%0d d=%0d want i=1 d=0", ai_cnt - bi, ad_cnt - bd);
        else npass++;
    endtask

    task automatic test_priority();
        int d_k = -1, i_k = -1, nrise = 0;
        int rise_k [4];
        logic prev = 1'b0;
        logic [31:0] d_data = '0, i_data = '0;
        a_i_addr = 8'h04;
        a_d_addr = 8'h10;
        a_d_we   = 1'b0;
        a_i_req  = 1'b1;
        a_d_req  = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (a_mem_request && !prev && nrise < 4) begin
                rise_k[nrise] = k;
                nrise++;
            end
            prev = a_mem_request;
            if (a_d_valid) begin
                d_k = k;
                d_data = a_d_rdata;
                a_d_req = 1'b0;
            end
            if (a_i_valid) begin
                i_k = k;
                i_data = a_i_rdata;
                a_i_req = 1'b0;
            end
        end
        a_i_req = 1'b0;
        a_d_req = 1'b0;
        ntotal++;
        if (!(d_k >= 0 && i_k > d_k))
            $display("FAIL prio_order: got d_valid@%0d i_valid@%0d want d before i", d_k, i_k);
        else npass++;
        ntotal++;
        if (d_data !== 32'hA5A5A510) $display("FAIL prio_d_rdata: got %h want a5a5a510", d_data);
        else npass++;
        ntotal++;
        if (i_data !== 32'hA5A5A504) $display("FAIL prio_i_rdata: got %h want a5a5a504", i_data);
        else npass++;
        // Grant in IDLE two cycles after d_valid, so the request rises three cycles after it.
        ntotal++;
        if (nrise != 2 || rise_k[1] != d_k + 3)
            $display("FAIL prio_regrant: got rises=%0d second_rise@%0d want 2 rises, second@%0d",
                     nrise, rise_k[1], d_k + 3);
        else npass++;
    endtask

    task automatic test_store();
        int busy_n = 0, bad = 0;
        logic seen = 1'b0;
        lat_a     = 3;
        a_d_addr  = 8'h20;
        a_d_we    = 1'b1;
        a_d_wdata = 32'hDEADBEEF;
        a_d_mask  = 4'b0011;
        a_d_req   = 1'b1;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (a_mem_request) begin
                busy_n++;
                if ({a_mem_addr, a_mem_we, a_mem_wdata, a_mem_mask} !==
                    {8'h20, 1'b1, 32'hDEADBEEF, 4'b0011}) bad++;
            end
            if (a_d_valid) begin
                seen = 1'b1;
                a_d_req = 1'b0;
                a_d_we  = 1'b0;
                a_d_mask = 4'h0;
            end
        end
        ntotal++;
        if (!seen || bad != 0)
            $display("FAIL store_stable: got valid=%b unstable_cycles=%0d want 1/0", seen, bad);
        else npass++;
        ntotal++;
        if (busy_n != 4) $display("FAIL store_busy_len: got %0d want 4", busy_n);
        else npass++;
        lat_a = 1;
        repeat (2) @(negedge clk);
        a_d_req = 1'b1;
        for (int k = 0; k < 20 && a_d_valid !== 1'b1; k++) @(negedge clk);
        ntotal++;
        if (a_d_valid !== 1'b1 || a_d_rdata !== 32'h1234BEEF)
            $display("FAIL store_readback: got valid=%b data=%h want 1/1234beef", a_d_valid, a_d_rdata);
        else npass++;
        a_d_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout();
        int busy_n = 0, err_at = -1;
        int bd = ad_cnt;
        int bi, bie, bde, bd2;
        silent   = 1'b1;
        a_d_addr = 8'h30;
        a_d_we   = 1'b0;
        a_d_req  = 1'b1;
        for (int k = 0; k < 30 && err_at < 0; k++) begin
            @(negedge clk);
            if (a_mem_request) busy_n++;
            if (a_d_err) begin
                err_at = busy_n;
                a_d_req = 1'b0;
            end
        end
        a_d_req = 1'b0;
        ntotal++;
        if (err_at != 8) $display("FAIL timeout_err_cycle: got %0d want 8", err_at);
        else npass++;
        repeat (3) @(negedge clk);
        silent = 1'b0;
        ntotal++;
        if (ad_cnt - bd !== 0) $display("FAIL timeout_no_valid: got %0d want 0", ad_cnt - bd);
        else npass++;
        bi = ai_cnt; bd2 = ad_cnt; bie = aie_cnt; bde = ade_cnt;
        inj_valid = 1'b1;
        @(negedge clk);
        inj_valid = 1'b0;
        repeat (3) @(negedge clk);
        ntotal++;
        if (ai_cnt != bi || ad_cnt != bd2 || aie_cnt != bie || ade_cnt != bde || a_mem_request)
            $display("FAIL late_valid_ignored: got pulses=%0d req=%b want 0/0",
                     (ai_cnt - bi) + (ad_cnt - bd2) + (aie_cnt - bie) + (ade_cnt - bde),
                     a_mem_request);
        else npass++;
    endtask

    task automatic test_rr();
        logic [3:0] order = '0;
        int n = 0, bad_data = 0;
        b_i_addr = 8'h04;
        b_d_addr = 8'h10;
        b_i_req  = 1'b1;
        b_d_req  = 1'b1;
        for (int k = 0; k < 60 && n < 4; k++) begin
            @(negedge clk);
            if (b_i_valid) begin
                order = {order[2:0], 1'b0};
                if (b_i_rdata !== 32'hA5A5A504) bad_data++;
                n++;
            end
            if (b_d_valid) begin
                order = {order[2:0], 1'b1};
                if (b_d_rdata !== 32'hA5A5A510) bad_data++;
                n++;
            end
        end
        b_i_req = 1'b0;
        b_d_req = 1'b0;
        ntotal++;
        if (n != 4 || order !== 4'b0101)
            $display("FAIL rr_alternate: got n=%0d order=%b want 4/0101 (I,D,I,D)", n, order);
        else npass++;
        ntotal++;
        if (bad_data != 0) $display("FAIL rr_rdata: got %0d bad words want 0", bad_data);
        else npass++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        int bi = ai_cnt, bd = ad_cnt, bie = aie_cnt, bde = ade_cnt;
        lat_a    = 4;
        a_d_addr = 8'h10;
        a_d_we   = 1'b0;
        a_d_req  = 1'b1;
        @(negedge clk);
        ntotal++;
        if (a_mem_request !== 1'b1) $display("FAIL rst_mid_setup: got %b want 1", a_mem_request);
        else npass++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        ntotal++;
        if (a_mem_request !== 1'b0) $display("FAIL rst_async_drop: got %b want 0", a_mem_request);
        else npass++;
        a_d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        ntotal++;
        if (ai_cnt != bi || ad_cnt != bd || aie_cnt != bie || ade_cnt != bde)
            $display("FAIL rst_no_pulse: got %0d pulses want 0",
                     (ai_cnt - bi) + (ad_cnt - bd) + (aie_cnt - bie) + (ade_cnt - bde));
        else npass++;
        lat_a   = 1;
        a_d_req = 1'b1;
        for (int k = 0; k < 20 && a_d_valid !== 1'b1; k++) @(negedge clk);
        ntotal++;
        if (a_d_valid !== 1'b1 || a_d_rdata !== 32'hA5A5A510)
            $display("FAIL rst_recover: got valid=%b data=%h want 1/a5a5a510", a_d_valid, a_d_rdata);
        else npass++;
        a_d_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_timeout();
        test_rr();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
